mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline, fed by the EX/MEM register and feeding MEM/WB.

---
 rtl/mem_access_stage_pkg.sv | 19 +
 rtl/mem_access_stage_data_memory.sv | 45 ++++
 rtl/mem_access_stage.sv | 93 +++++++++
 tb/tb_mem_access_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and helpers for the MEM stage: access-size codes and the byte-lane mask.
package mem_access_stage_pkg;

  localparam logic [1:0] BHW_BYTE = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_WORD = 2'b10;

  // Reserved size code 2'b11 behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] bhw, input logic [1:0] off);
    logic [3:0] mask;
    case (bhw)
      BHW_BYTE: mask = 4'b0001 << off;
      BHW_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_stage_data_memory.sv
// Four-byte-lane data RAM: one write port with byte enables, one async read port,
// one registered debug read port.
module data_memory #(
  parameter int INST_SZ = 32,
  parameter int ADDR_W  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_we,
  input  logic [3:0]         i_be,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [INST_SZ-1:0] i_wdata,
  output logic [INST_SZ-1:0] o_rdata,
  input  logic               i_dbg_req,
  input  logic [ADDR_W-1:0]  i_dbg_addr,
  output logic [INST_SZ-1:0] o_dbg_data,
  output logic               o_dbg_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INST_SZ-1:0] mem [0:DEPTH-1];

  // No reset on the array so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_we && !i_reset) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  assign o_rdata = mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dbg_valid <= 1'b0;
      o_dbg_data  <= '0;
    end else begin
      o_dbg_valid <= i_dbg_req;
      if (i_dbg_req) o_dbg_data <= mem[i_dbg_addr];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: store lane merge, extended loads, debug dump port.
// Optional ALIGN_CHECK_EN macro enables misalignment suppression and a sticky error flag.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int INST_SZ = 32,
  parameter int ADDR_W  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_bhw,
  input  logic               i_load_unsigned,
  input  logic [INST_SZ-1:0] i_addr,
  input  logic [INST_SZ-1:0] i_write_data,
  output logic [INST_SZ-1:0] o_read_data,
  input  logic               i_dbg_req,
  input  logic [ADDR_W-1:0]  i_dbg_addr,
  output logic [INST_SZ-1:0] o_dbg_data,
  output logic               o_dbg_valid,
  output logic               o_align_err
);

  logic [ADDR_W-1:0]  word_idx;
  logic [1:0]         off;
  logic [INST_SZ-1:0] store_data;
  logic [INST_SZ-1:0] rword;
  logic [INST_SZ-1:0] byte_shift;
  logic [15:0]        half_sel;
  logic [INST_SZ-1:0] load_data;
  logic               misaligned;
  logic               we;

  assign word_idx = i_addr[ADDR_W+1:2];
  assign off      = i_addr[1:0];

`ifdef ALIGN_CHECK_EN
  assign misaligned = ((i_bhw == BHW_HALF) && off[0]) || (i_bhw[1] && (off != 2'b00));

  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_align_err <= 1'b0;
    else if (i_enable && (i_mem_read || i_mem_write) && misaligned)
      o_align_err <= 1'b1;
  end
`else
  assign misaligned  = 1'b0;
  assign o_align_err = 1'b0;
`endif

  // Replicate store data to every lane; the byte enables pick the target lanes.
  always_comb begin
    store_data = i_write_data;
    case (i_bhw)
      BHW_BYTE: store_data = {4{i_write_data[7:0]}};
      BHW_HALF: store_data = {2{i_write_data[15:0]}};
      default:  store_data = i_write_data;
    endcase
  end

  assign we = i_mem_write && i_enable && !misaligned;

  data_memory #(.INST_SZ(INST_SZ), .ADDR_W(ADDR_W)) u_data_memory (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_we        (we),
    .i_be        (lane_mask(i_bhw, off)),
    .i_addr      (word_idx),
    .i_wdata     (store_data),
    .o_rdata     (rword),
    .i_dbg_req   (i_dbg_req && !i_enable),
    .i_dbg_addr  (i_dbg_addr),
    .o_dbg_data  (o_dbg_data),
    .o_dbg_valid (o_dbg_valid)
  );

  assign byte_shift = rword >> {off, 3'b000};
  assign half_sel   = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    case (i_bhw)
      BHW_BYTE: load_data = {{24{!i_load_unsigned && byte_shift[7]}}, byte_shift[7:0]};
      BHW_HALF: load_data = {{16{!i_load_unsigned && half_sel[15]}}, half_sel};
      default:  load_data = rword;
    endcase
  end

  assign o_read_data = (i_mem_read && !misaligned) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; expectations follow ALIGN_CHECK_EN if defined.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int INST_SZ = 32;
  localparam int ADDR_W  = 10;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_enable;
  logic               i_mem_read;
  logic               i_mem_write;
  logic [1:0]         i_bhw;
  logic               i_load_unsigned;
  logic [INST_SZ-1:0] i_addr;
  logic [INST_SZ-1:0] i_write_data;
  logic [INST_SZ-1:0] o_read_data;
  logic               i_dbg_req;
  logic [ADDR_W-1:0]  i_dbg_addr;
  logic [INST_SZ-1:0] o_dbg_data;
  logic               o_dbg_valid;
  logic               o_align_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.INST_SZ(INST_SZ), .ADDR_W(ADDR_W)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_mem_read      (i_mem_read),
    .i_mem_write     (i_mem_write),
    .i_bhw           (i_bhw),
    .i_load_unsigned (i_load_unsigned),
    .i_addr          (i_addr),
    .i_write_data    (i_write_data),
    .o_read_data     (o_read_data),
    .i_dbg_req       (i_dbg_req),
    .i_dbg_addr      (i_dbg_addr),
    .o_dbg_data      (o_dbg_data),
    .o_dbg_valid     (o_dbg_valid),
    .o_align_err     (o_align_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] bhw, input logic en);
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b1;
    i_enable     = en;
    i_addr       = addr;
    i_write_data = data;
    i_bhw        = bhw;
    tick();
    i_mem_write  = 1'b0;
    i_enable     = 1'b1;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] bhw,
                          input logic uns, input logic [31:0] exp);
    i_mem_read      = 1'b1;
    i_mem_write     = 1'b0;
    i_addr          = addr;
    i_bhw           = bhw;
    i_load_unsigned = uns;
    #1;
    chk(tag, o_read_data, exp);
    i_mem_read      = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_bhw = BHW_WORD; i_load_unsigned = 1'b0; i_addr = '0; i_write_data = '0;
    i_dbg_req = 1'b0; i_dbg_addr = '0;
    tick(); tick();
    chk("rst_dbg_data", o_dbg_data, 32'h0);
    chk("rst_dbg_valid", {31'b0, o_dbg_valid}, 32'h0);
    chk("rst_align_err", {31'b0, o_align_err}, 32'h0);
    i_reset = 1'b0;
    tick();

    store(32'h10, 32'hDEADBEEF, BHW_WORD, 1'b1);
    i_addr = 32'h10; i_bhw = BHW_WORD; #1;
    chk("no_read_zero", o_read_data, 32'h0);
    load_chk("lw_10", 32'h10, BHW_WORD, 1'b0, 32'hDEADBEEF);

    store(32'h11, 32'h00000080, BHW_BYTE, 1'b1);
    load_chk("lb_11", 32'h11, BHW_BYTE, 1'b0, 32'hFFFFFF80);
    load_chk("lbu_11", 32'h11, BHW_BYTE, 1'b1, 32'h00000080);
    load_chk("lw_after_sb", 32'h10, BHW_WORD, 1'b0, 32'hDEAD80EF);

    store(32'h12, 32'h00001234, BHW_HALF, 1'b1);
    load_chk("lh_12", 32'h12, BHW_HALF, 1'b0, 32'h00001234);
    load_chk("lw_after_sh", 32'h10, BHW_WORD, 1'b0, 32'h123480EF);
    load_chk("lbu_13", 32'h13, BHW_BYTE, 1'b1, 32'h00000012);

    store(32'h20, 32'h00008765, BHW_HALF, 1'b1);
    load_chk("lh_20_sext", 32'h20, BHW_HALF, 1'b0, 32'hFFFF8765);
    load_chk("lhu_20", 32'h20, BHW_HALF, 1'b1, 32'h00008765);

    store(32'h10, 32'h00000055, BHW_WORD, 1'b0);
    load_chk("lw_stalled_store", 32'h10, BHW_WORD, 1'b0, 32'h123480EF);

    // Address bits above the word index are ignored.
    store(32'h1030, 32'hCAFEF00D, BHW_WORD, 1'b1);
    load_chk("lw_wrap", 32'h30, BHW_WORD, 1'b0, 32'hCAFEF00D);
    store(32'h4, 32'h11223344, BHW_RSVD_WORD(), 1'b1);
    load_chk("lw_rsvd_size", 32'h4, 2'b11, 1'b0, 32'h11223344);

    i_enable = 1'b0; i_dbg_req = 1'b1; i_dbg_addr = 10'd4;
    tick();
    chk("dbg_valid_1", {31'b0, o_dbg_valid}, 32'h1);
    chk("dbg_data_4", o_dbg_data, 32'h123480EF);
    i_dbg_addr = 10'd12;
    tick();
    chk("dbg_valid_b2b", {31'b0, o_dbg_valid}, 32'h1);
    chk("dbg_data_12", o_dbg_data, 32'hCAFEF00D);
    i_enable = 1'b1; i_dbg_addr = 10'd4;
    tick();
    chk("dbg_ignored_valid", {31'b0, o_dbg_valid}, 32'h0);
    chk("dbg_ignored_hold", o_dbg_data, 32'hCAFEF00D);
    i_dbg_req = 1'b0;

    store(32'h13, 32'hFFFFFFFF, BHW_WORD, 1'b1);
`ifdef ALIGN_CHECK_EN
    load_chk("misaligned_sw_dropped", 32'h10, BHW_WORD, 1'b0, 32'h123480EF);
    chk("align_err_set", {31'b0, o_align_err}, 32'h1);
    load_chk("misaligned_lh_zero", 32'h11, BHW_HALF, 1'b0, 32'h0);
    tick();
    chk("align_err_sticky", {31'b0, o_align_err}, 32'h1);
`else
    load_chk("unaligned_sw_writes", 32'h10, BHW_WORD, 1'b0, 32'hFFFFFFFF);
    chk("align_err_tied", {31'b0, o_align_err}, 32'h0);
    store(32'h11, 32'h0000ABCD, BHW_HALF, 1'b1);
    load_chk("unaligned_sh_low", 32'h10, BHW_HALF, 1'b1, 32'h0000ABCD);
`endif

    i_enable = 1'b0; i_dbg_req = 1'b1; i_dbg_addr = 10'd4; i_reset = 1'b1;
    tick();
    chk("rst_mid_dbg_valid", {31'b0, o_dbg_valid}, 32'h0);
    chk("rst_mid_dbg_data", o_dbg_data, 32'h0);
    chk("rst_mid_align_err", {31'b0, o_align_err}, 32'h0);
    i_dbg_req = 1'b0; i_reset = 1'b0; i_enable = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, o_dbg_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  function automatic logic [1:0] BHW_RSVD_WORD();
    return 2'b11;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
